// File: rtl/cnn_pkg.sv
// Shared fixed-point types and helpers for the PPG->CO CNN datapath.
package cnn_pkg;

    typedef logic signed [15:0] q4_12_t;
    typedef q4_12_t vec16_t [16];

    // Negative samples, including the most negative code 16'h8000, map to zero.
    function automatic q4_12_t relu_q(input q4_12_t x);
        return x[15] ? q4_12_t'(0) : x;
    endfunction

endpackage

// File: rtl/relu_max_lane.sv
// One channel of ReLU followed by a running max against the window accumulator.
module relu_max_lane
    import cnn_pkg::*;
(
    input  q4_12_t x,
    input  q4_12_t acc,
    input  logic   first,
    output q4_12_t y
);

    q4_12_t r;

    always_comb begin
        r = relu_q(x);
        y = r;
        if (!first && (acc > r)) begin
            y = acc;
        end
    end

endmodule

// File: rtl/relu_maxpool3.sv
// ReLU + 1-D temporal max-pool after batch-norm layer 3, with ready/valid on both sides.
module relu_maxpool3
    import cnn_pkg::*;
#(
    parameter int N_CH   = 16,
    parameter int DATA_W = 16,
    parameter int POOL_K = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   valid_in,
    input  logic   last_in,
    input  q4_12_t input_data [N_CH],
    output logic   ready_out,
    output q4_12_t output_data [N_CH],
    output logic   valid_out,
    output logic   last_out,
    input  logic   ready_in
);

    localparam int CNT_W = (POOL_K > 1) ? $clog2(POOL_K) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POOL_K - 1);

    generate
        if (DATA_W != $bits(q4_12_t)) begin : g_bad_width
            $error("relu_maxpool3: DATA_W must match q4_12_t");
        end
        if (POOL_K < 1 || POOL_K > 8) begin : g_bad_pool
            $error("relu_maxpool3: POOL_K out of range 1..8");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_p0;
    q4_12_t           acc_p0 [N_CH];
    q4_12_t           m_p0   [N_CH];
    logic             first_p0;
    logic             acc_beat;
    logic             win_close;
    logic             retire;

    // Input only stalls while a finished result is waiting on the consumer.
    assign ready_out = !(valid_out && !ready_in);
    assign acc_beat  = valid_in && ready_out;
    assign first_p0  = (cnt_p0 == '0);
    assign win_close = acc_beat && ((cnt_p0 == CNT_LAST) || last_in);
    assign retire    = valid_out && ready_in;

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        relu_max_lane u_lane (
            .x     (input_data[c]),
            .acc   (acc_p0[c]),
            .first (first_p0),
            .y     (m_p0[c])
        );
    end

    // Stage p0 -> p1: window accumulate / close into the output register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_p0    <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                acc_p0[c]      <= '0;
                output_data[c] <= '0;
            end
        end else if (win_close) begin
            cnt_p0    <= '0;
            valid_out <= 1'b1;
            last_out  <= last_in;
            for (int c = 0; c < N_CH; c++) begin
                output_data[c] <= m_p0[c];
            end
        end else begin
            if (acc_beat) begin
                cnt_p0 <= cnt_p0 + 1'b1;
                for (int c = 0; c < N_CH; c++) begin
                    acc_p0[c] <= m_p0[c];
                end
            end
            if (retire) begin
                valid_out <= 1'b0;
                last_out  <= 1'b0;
            end
        end
    end

endmodule
